// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and helpers for the 7-segment scan controller
package seg7_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        DEAD = 1'b1
    } state_e;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Bit idx set in a 32-bit word; callers narrow it to their digit count.
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned n);
        logic [31:0] v;
        v = '0;
        if ((idx < n) && (idx < 32)) begin
            v = 32'd1 << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// rtl/seg7_lz_mask.sv - leading-zero suppress mask, scanned from the most significant digit down
module seg7_lz_mask
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   mask
);

    logic zero_run;

    // Digit 0 is left out of the scan so a zero value still shows "0".
    always_comb begin
        zero_run = 1'b1;
        mask     = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (digits[4*i +: 4] == 4'd0);
            mask[i]  = zero_run;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment digit scanner with frame-synchronous value loading
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    lz_suppress,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    blank,
    output logic                    frame_tick
);

    localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] DEAD_LAST = TW'(BLANK_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    run_q, run_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    lz_q, lz_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_lz_q, pend_lz_d;
    logic                    pend_vld_q, pend_vld_d;

    logic                    show_done;
    logic                    dead_done;
    logic                    frame_end;
    logic                    xfer;
    logic [NUM_DIGITS-1:0]   lz_mask;

    seg7_lz_mask #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_lz_mask (
        .digits(disp_q),
        .mask  (lz_mask)
    );

    assign show_done = (state_q == SHOW) && (timer_q == SHOW_LAST);
    assign dead_done = (state_q == DEAD) && (timer_q == DEAD_LAST);
    // run_q holds the scan for the single cycle the reset state is visible,
    // so cycle 1 after release is the first counted DEAD cycle.
    assign frame_end = run_q && dead_done && (idx_q == LAST_IDX);
    assign xfer      = load_valid && !pend_vld_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        run_d      = 1'b1;
        disp_d     = disp_q;
        lz_d       = lz_q;
        pend_d     = pend_q;
        pend_lz_d  = pend_lz_q;
        pend_vld_d = pend_vld_q;

        if (run_q) begin
            if (show_done) begin
                state_d = DEAD;
                timer_d = '0;
            end else if (dead_done) begin
                state_d = SHOW;
                timer_d = '0;
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        // Only a value pending before the boundary cycle is applied; one
        // captured on the boundary itself waits a whole frame.
        if (frame_end && pend_vld_q) begin
            disp_d     = pend_q;
            lz_d       = pend_lz_q;
            pend_vld_d = 1'b0;
        end

        if (xfer) begin
            pend_d     = load_value;
            pend_lz_d  = lz_suppress;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= DEAD;
            idx_q      <= LAST_IDX;
            timer_q    <= '0;
            run_q      <= 1'b0;
            disp_q     <= '0;
            lz_q       <= 1'b0;
            pend_q     <= '0;
            pend_lz_q  <= 1'b0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            run_q      <= run_d;
            disp_q     <= disp_d;
            lz_q       <= lz_d;
            pend_q     <= pend_d;
            pend_lz_q  <= pend_lz_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    always_comb begin
        digit_sel = '0;
        bcd_out   = BCD_BLANK;
        if (state_q == SHOW) begin
            digit_sel = NUM_DIGITS'(onehot(32'(idx_q), NUM_DIGITS));
            if (!(lz_q && lz_mask[idx_q])) begin
                bcd_out = disp_q[4*idx_q +: 4];
            end
        end
    end

    assign blank      = (state_q != SHOW);
    assign frame_tick = frame_end;
    assign load_ready = !pend_vld_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic        lz_suppress;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        blank;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .lz_suppress(lz_suppress),
        .bcd_out    (bcd_out),
        .digit_sel  (digit_sel),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Starts at a frame_tick cycle and ends on the next one; records the
    // first lit cycle of each digit.
    task automatic scan_frame(output logic [15:0] b, output logic [15:0] s,
                              output logic ft, output logic rdy);
        b   = '0;
        s   = '0;
        rdy = 1'b0;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 5; p++) begin
                tick();
                if (d == 0 && p == 0) rdy = load_ready;
                if (p == 0) begin
                    b[4*d +: 4] = bcd_out;
                    s[4*d +: 4] = digit_sel;
                end
            end
        end
        ft = frame_tick;
    endtask

    task automatic load(input logic [15:0] v, input logic lz);
        load_valid  = 1'b1;
        load_value  = v;
        lz_suppress = lz;
        tick();
        load_valid  = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got, exp;
        int dig, pos;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({digit_sel, blank, bcd_out, load_ready, frame_tick} !== {4'b0000, 1'b1, 4'hF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold got sel=%b blank=%b bcd=%h rdy=%b ft=%b exp sel=0000 blank=1 bcd=f rdy=1 ft=0",
                     digit_sel, blank, bcd_out, load_ready, frame_tick);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({frame_tick, digit_sel} !== 5'b1_0000) begin
            errors++;
            $display("FAIL reset_first_tick got ft=%b sel=%b exp ft=1 sel=0000", frame_tick, digit_sel);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            dig = c / 5;
            pos = c % 5;
            exp = (pos < 4) ? {4'(1 << dig), 1'b0, 4'h0} : {4'b0000, 1'b1, 4'hF};
            exp = {exp[4:0], (c == 19) ? 1'b1 : 1'b0, 1'b1} | 7'b0 ;
            got = {digit_sel[3:0], blank, frame_tick, load_ready} ;
            checks++;
            if (got !== {((pos < 4) ? 4'(1 << dig) : 4'b0000), (pos == 4), (c == 19), 1'b1}
                || bcd_out !== ((pos < 4) ? 4'h0 : 4'hF)) begin
                errors++;
                $display("FAIL reset_scan c=%0d got sel=%b blank=%b ft=%b rdy=%b bcd=%h exp sel=%b blank=%b ft=%b bcd=%h",
                         c, digit_sel, blank, frame_tick, load_ready, bcd_out,
                         (pos < 4) ? 4'(1 << dig) : 4'b0000, pos == 4, c == 19, (pos < 4) ? 4'h0 : 4'hF);
            end
        end
    endtask

    task automatic test_load_1234();
        bit ok;
        logic [15:0] b, s;
        logic ft, rdy;
        tick();
        load(16'h1234, 1'b0);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready_fall got %b exp 0", load_ready);
        end
        wait_tick(ok);
        checks++;
        if (!ok || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_boundary got found=%0d rdy=%b exp found=1 rdy=0", ok, load_ready);
        end
        scan_frame(b, s, ft, rdy);
        checks++;
        if ({b, s, ft, rdy} !== {16'h1234, 16'h8421, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL load_1234_frame got bcd=%h sel=%h ft=%b rdy=%b exp bcd=1234 sel=8421 ft=1 rdy=1",
                     b, s, ft, rdy);
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [4] = '{16'h0070, 16'h0000, 16'h0905, 16'hA0B3};
        logic        lzs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] exps [4] = '{16'hFF70, 16'hFFF0, 16'hF905, 16'hA0B3};
        bit ok;
        logic [15:0] b, s;
        logic ft, rdy;
        for (int k = 0; k < 4; k++) begin
            tick();
            load(vals[k], lzs[k]);
            wait_tick(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL lz_wait k=%0d got no frame_tick exp frame_tick within 40 cycles", k);
            end
            scan_frame(b, s, ft, rdy);
            checks++;
            if ({b, s, ft} !== {exps[k], 16'h8421, 1'b1}) begin
                errors++;
                $display("FAIL lz_frame k=%0d got bcd=%h sel=%h ft=%b exp bcd=%h sel=8421 ft=1",
                         k, b, s, ft, exps[k]);
            end
        end
    endtask

    task automatic test_simul();
        bit ok;
        logic [15:0] b, s;
        logic ft, rdy;
        checks++;
        if (frame_tick !== 1'b1 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_start got ft=%b rdy=%b exp ft=1 rdy=1", frame_tick, load_ready);
        end
        load(16'h5678, 1'b0);
        checks++;
        if ({load_ready, digit_sel, bcd_out} !== {1'b0, 4'b0001, 4'h3}) begin
            errors++;
            $display("FAIL simul_old_frame got rdy=%b sel=%b bcd=%h exp rdy=0 sel=0001 bcd=3",
                     load_ready, digit_sel, bcd_out);
        end
        wait_tick(ok);
        scan_frame(b, s, ft, rdy);
        checks++;
        if (!ok || {b, s, ft, rdy} !== {16'h5678, 16'h8421, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL simul_new_frame got found=%0d bcd=%h sel=%h ft=%b rdy=%b exp found=1 bcd=5678 sel=8421 ft=1 rdy=1",
                     ok, b, s, ft, rdy);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int i;
        logic [15:0] b, s;
        logic ft, rdy;
        tick();
        load_valid  = 1'b1;
        load_value  = 16'h1111;
        lz_suppress = 1'b0;
        tick();
        load_value  = 16'h2222;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready_low got %b exp 0", load_ready);
        end
        for (i = 0; i < 40; i++) begin
            tick();
            if (load_ready) break;
        end
        checks++;
        if (i >= 40 || {digit_sel, bcd_out} !== {4'b0001, 4'h1}) begin
            errors++;
            $display("FAIL hold_first_value got waited=%0d sel=%b bcd=%h exp sel=0001 bcd=1",
                     i, digit_sel, bcd_out);
        end
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_second_capture got rdy=%b exp 0", load_ready);
        end
        wait_tick(ok);
        scan_frame(b, s, ft, rdy);
        checks++;
        if (!ok || {b, s, ft} !== {16'h2222, 16'h8421, 1'b1}) begin
            errors++;
            $display("FAIL hold_second_frame got found=%0d bcd=%h sel=%h ft=%b exp found=1 bcd=2222 sel=8421 ft=1",
                     ok, b, s, ft);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] b, s;
        logic ft, rdy;
        tick();
        load(16'h9999, 1'b0);
        tick();
        checks++;
        if ({digit_sel, load_ready} !== {4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL mid_pre_reset got sel=%b rdy=%b exp sel=0001 rdy=0", digit_sel, load_ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({digit_sel, blank, bcd_out, load_ready, frame_tick} !== {4'b0000, 1'b1, 4'hF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_async_reset got sel=%b blank=%b bcd=%h rdy=%b ft=%b exp sel=0000 blank=1 bcd=f rdy=1 ft=0",
                     digit_sel, blank, bcd_out, load_ready, frame_tick);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL mid_first_tick got %b exp 1", frame_tick);
        end
        scan_frame(b, s, ft, rdy);
        checks++;
        if ({b, s, ft, rdy} !== {16'h0000, 16'h8421, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_after_reset got bcd=%h sel=%h ft=%b rdy=%b exp bcd=0000 sel=8421 ft=1 rdy=1",
                     b, s, ft, rdy);
        end
    endtask

    initial begin
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_value  = '0;
        lz_suppress = 1'b0;
        test_reset();
        test_load_1234();
        test_lz();
        test_simul();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
